// File: rtl/pio_in_edge_debounce.sv
// ----------------------------------------------------------------------------
// pio_in_edge_debounce
//   Avalon-MM input PIO for push-buttons and switches. External inputs pass
//   through a 2-flop synchroniser and a per-bit debounce filter whose period
//   is programmable. Debounced edges are qualified by per-bit rise/fall
//   enables and latched into a W1C capture register. A second edge arriving
//   while a capture bit is still pending sets a W1C overrun flag. A masked
//   level interrupt is raised while any enabled capture bit is pending.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address (0 data, 1 raw, 2 irq_mask, 3 capture,
//               4 rise_en, 5 fall_en, 6 db_period, 7 overrun)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    registered read data, one cycle after address
//   irq         level interrupt, active high, decoded from flops only
// ----------------------------------------------------------------------------
module pio_in_edge_debounce #(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned DB_W       = 16,
    parameter logic [31:0] RESET_MASK = 32'h0000_0000,
    parameter logic [31:0] RESET_RISE = 32'h0000_0000,
    parameter logic [31:0] RESET_FALL = 32'hFFFF_FFFF,
    parameter logic [31:0] RESET_DB   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;

    localparam logic [AW-1:0] ADDR_DATA    = AW'(0);
    localparam logic [AW-1:0] ADDR_RAW     = AW'(1);
    localparam logic [AW-1:0] ADDR_MASK    = AW'(2);
    localparam logic [AW-1:0] ADDR_CAPTURE = AW'(3);
    localparam logic [AW-1:0] ADDR_RISE    = AW'(4);
    localparam logic [AW-1:0] ADDR_FALL    = AW'(5);
    localparam logic [AW-1:0] ADDR_PERIOD  = AW'(6);
    localparam logic [AW-1:0] ADDR_OVERRUN = AW'(7);

    // Synchroniser, debounce and edge-detect state
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_db;
    logic [WIDTH-1:0] r_db_q;
    logic [DB_W-1:0]  r_cnt [WIDTH];

    // Software-visible registers
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_cap;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_ovr;
    logic [DB_W-1:0]  r_period;
    logic [DW-1:0]    r_readdata;

    // Combinational next-state terms
    logic             w_wr;
    logic             w_period_wr;
    logic [DB_W-1:0]  w_p_last;
    logic [WIDTH-1:0] w_db_nxt;
    logic [DB_W-1:0]  w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_cap_w1c;
    logic [WIDTH-1:0] w_ovr_w1c;
    logic [WIDTH-1:0] w_cap_nxt;
    logic [WIDTH-1:0] w_ovr_nxt;
    logic [DW-1:0]    w_rdata;
    logic             w_unused_wdata;

    // Bus decode
    assign w_wr        = chipselect & ~write_n;
    assign w_period_wr = w_wr && (address == ADDR_PERIOD);

    // Upper writedata bits are architecturally ignored
    assign w_unused_wdata = ^writedata;

    // Last count value before a change passes; a period of 0 behaves as 1
    assign w_p_last = (r_period == '0) ? '0 : r_period - DB_W'(1);

    // Per-bit debounce: a disagreement between s2 and db must persist for
    // P consecutive clocks before db follows. Any agreement restarts the
    // count, and a period write restarts every count without passing a bit.
    always_comb begin
        w_db_nxt = r_db;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_cnt_nxt[i] = r_cnt[i];
        end
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (w_period_wr) begin
                w_cnt_nxt[i] = '0;
            end else if (r_s2[i] == r_db[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == w_p_last) begin
                w_db_nxt[i]  = r_s2[i];
                w_cnt_nxt[i] = '0;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + DB_W'(1);
            end
        end
    end

    // Edge qualification, capture and overrun. A new event always wins over
    // a simultaneous W1C so that no edge is lost; overrun is only flagged
    // when software is not acknowledging the same bit in that cycle.
    always_comb begin
        w_ev      = (r_rise & r_db & ~r_db_q) | (r_fall & ~r_db & r_db_q);
        w_cap_w1c = '0;
        w_ovr_w1c = '0;
        if (w_wr && (address == ADDR_CAPTURE)) begin
            w_cap_w1c = writedata[WIDTH-1:0];
        end
        if (w_wr && (address == ADDR_OVERRUN)) begin
            w_ovr_w1c = writedata[WIDTH-1:0];
        end
        w_cap_nxt = (r_cap & ~w_cap_w1c) | w_ev;
        w_ovr_nxt = (r_ovr & ~w_ovr_w1c) | (w_ev & r_cap & ~w_cap_w1c);
    end

    // Read mux, zero-extended; registered below independent of chipselect
    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:    w_rdata = DW'(r_db);
            ADDR_RAW:     w_rdata = DW'(r_s2);
            ADDR_MASK:    w_rdata = DW'(r_mask);
            ADDR_CAPTURE: w_rdata = DW'(r_cap);
            ADDR_RISE:    w_rdata = DW'(r_rise);
            ADDR_FALL:    w_rdata = DW'(r_fall);
            ADDR_PERIOD:  w_rdata = DW'(r_period);
            ADDR_OVERRUN: w_rdata = DW'(r_ovr);
            default:      w_rdata = '0;
        endcase
    end

    // Input path and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_db       <= '0;
            r_db_q     <= '0;
            r_cap      <= '0;
            r_ovr      <= '0;
            r_readdata <= '0;
        end else begin
            r_s1       <= in_port;
            r_s2       <= r_s1;
            r_db       <= w_db_nxt;
            r_db_q     <= r_db;
            r_cap      <= w_cap_nxt;
            r_ovr      <= w_ovr_nxt;
            r_readdata <= w_rdata;
        end
    end

    // Debounce counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Software-writable configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask   <= RESET_MASK[WIDTH-1:0];
            r_rise   <= RESET_RISE[WIDTH-1:0];
            r_fall   <= RESET_FALL[WIDTH-1:0];
            r_period <= RESET_DB[DB_W-1:0];
        end else if (w_wr) begin
            case (address)
                ADDR_MASK:   r_mask   <= writedata[WIDTH-1:0];
                ADDR_RISE:   r_rise   <= writedata[WIDTH-1:0];
                ADDR_FALL:   r_fall   <= writedata[WIDTH-1:0];
                ADDR_PERIOD: r_period <= writedata[DB_W-1:0];
                default:     ;
            endcase
        end
    end

    assign readdata = r_readdata;

    // Decoded purely from flops so the level cannot glitch on bus activity
    assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_pio_in_edge_debounce.sv
module tb_pio_in_edge_debounce;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned DB_W  = 16;

    logic              clk;
    logic              reset_n;
    logic [2:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [WIDTH-1:0]  in_port;
    logic [31:0]       readdata;
    logic              irq;

    int n_pass;
    int n_chk;

    pio_in_edge_debounce #(
        .WIDTH (WIDTH),
        .DB_W  (DB_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Debounce is modelled from the history of synchronised samples: a bit
    // follows once its last P samples (all taken after its previous change
    // or the last period write) disagree with the current debounced value.
    logic [WIDTH-1:0] m_s1, m_s2, m_db, m_dbq, m_mask, m_cap, m_rise, m_fall, m_ovr;
    logic [DB_W-1:0]  m_per;
    logic [31:0]      m_rd;
    logic             m_irq;
    logic [WIDTH-1:0] s2h[$];
    int               k;
    int               last_clr[WIDTH];

    function automatic logic [31:0] m_mux(input logic [2:0] a);
        case (a)
            3'd0: return {29'b0, m_db};
            3'd1: return {29'b0, m_s2};
            3'd2: return {29'b0, m_mask};
            3'd3: return {29'b0, m_cap};
            3'd4: return {29'b0, m_rise};
            3'd5: return {29'b0, m_fall};
            3'd6: return {16'b0, m_per};
            default: return {29'b0, m_ovr};
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_dbq = '0;
        m_mask = '0; m_cap = '0; m_rise = '0; m_fall = 3'b111; m_ovr = '0;
        m_per = '0; m_rd = '0; m_irq = 1'b0;
        s2h.delete();
        k = 0;
        for (int i = 0; i < int'(WIDTH); i++) last_clr[i] = -1;
    endtask

    task automatic model_step();
        logic             wr;
        logic             pw;
        logic [WIDTH-1:0] ev, cw, ow, ndb, ncap, novr;
        int               p;
        bit               all_diff;
        wr   = chipselect && !write_n;
        m_rd = m_mux(address);
        ev   = (m_rise & m_db & ~m_dbq) | (m_fall & ~m_db & m_dbq);
        cw   = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
        ow   = (wr && address == 3'd7) ? writedata[WIDTH-1:0] : '0;
        ncap = (m_cap & ~cw) | ev;
        novr = (m_ovr & ~ow) | (ev & m_cap & ~cw);
        p    = (m_per == '0) ? 1 : int'(m_per);
        pw   = wr && address == 3'd6;
        s2h.push_back(m_s2);
        ndb  = m_db;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (pw) begin
                last_clr[i] = k;
            end else if (k - last_clr[i] >= p) begin
                all_diff = 1'b1;
                for (int j = k - p + 1; j <= k; j++)
                    if (s2h[j][i] == m_db[i]) all_diff = 1'b0;
                if (all_diff) begin
                    ndb[i] = ~m_db[i];
                    last_clr[i] = k;
                end
            end
        end
        m_dbq = m_db;
        m_db  = ndb;
        m_s2  = m_s1;
        m_s1  = in_port;
        m_cap = ncap;
        m_ovr = novr;
        if (wr && address == 3'd2) m_mask = writedata[WIDTH-1:0];
        if (wr && address == 3'd4) m_rise = writedata[WIDTH-1:0];
        if (wr && address == 3'd5) m_fall = writedata[WIDTH-1:0];
        if (pw) m_per = writedata[DB_W-1:0];
        k++;
        m_irq = |(m_cap & m_mask);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [2:0] a, input logic w, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = ~w;
        writedata  = d;
        tick();
    endtask

    task automatic hold_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [2:0]  ra [6];
        logic [31:0] re [6];
        ra = '{3'd5, 3'd2, 3'd3, 3'd4, 3'd7, 3'd6};
        re = '{32'h7, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        in_port = 3'b111; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        reset_n = 1'b0;
        model_reset();
        #3;
        n_chk++; if (readdata !== 32'h0) $display("FAIL reset_readdata got %h want 0", readdata); else n_pass++;
        n_chk++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) cyc(3'd0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cyc(ra[i], 1'b0, 32'h0);
            n_chk++;
            if (readdata !== re[i]) $display("FAIL reset_reg addr%0d got %h want %h", ra[i], readdata, re[i]);
            else n_pass++;
        end
        cyc(3'd0, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h7) $display("FAIL reset_data got %h want 7", readdata); else n_pass++;
    endtask

    task automatic test_fall_capture();
        in_port = 3'b101;
        repeat (4) cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h0) $display("FAIL fall_cap_early got %h want 0", readdata); else n_pass++;
        cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h2) $display("FAIL fall_cap got %h want 2", readdata); else n_pass++;
        n_chk++; if (irq !== 1'b0) $display("FAIL fall_irq_unmasked got %b want 0", irq); else n_pass++;
        cyc(3'd2, 1'b1, 32'h2);
        n_chk++; if (irq !== 1'b1) $display("FAIL fall_irq_masked got %b want 1", irq); else n_pass++;
        cyc(3'd3, 1'b1, 32'h2);
        in_port = 3'b111;
        repeat (5) cyc(3'd0, 1'b0, 32'h0);
    endtask

    task automatic test_debounce();
        cyc(3'd6, 1'b1, 32'd10);
        in_port = 3'b110;
        repeat (9) cyc(3'd0, 1'b0, 32'h0);
        in_port = 3'b111;
        repeat (15) cyc(3'd0, 1'b0, 32'h0);
        cyc(3'd0, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h7) $display("FAIL glitch_data got %h want 7", readdata); else n_pass++;
        cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h0) $display("FAIL glitch_capture got %h want 0", readdata); else n_pass++;
        in_port = 3'b110;
        repeat (13) cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h0) $display("FAIL db_cap_early got %h want 0", readdata); else n_pass++;
        cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h1) $display("FAIL db_cap_edge13 got %h want 1", readdata); else n_pass++;
        cyc(3'd0, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h6) $display("FAIL db_data got %h want 6", readdata); else n_pass++;
    endtask

    task automatic test_w1c_race();
        cyc(3'd6, 1'b1, 32'd0);
        cyc(3'd2, 1'b1, 32'h3);
        n_chk++; if (irq !== 1'b1) $display("FAIL race_irq_on got %b want 1", irq); else n_pass++;
        in_port = 3'b111;
        repeat (5) cyc(3'd0, 1'b0, 32'h0);
        in_port = 3'b110;
        repeat (3) cyc(3'd0, 1'b0, 32'h0);
        cyc(3'd3, 1'b1, 32'h1);
        cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h1) $display("FAIL race_capture got %h want 1", readdata); else n_pass++;
        cyc(3'd7, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h0) $display("FAIL race_overrun got %h want 0", readdata); else n_pass++;
        cyc(3'd3, 1'b1, 32'h1);
        n_chk++; if (irq !== 1'b0) $display("FAIL w1c_irq_drop got %b want 0", irq); else n_pass++;
        cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h0) $display("FAIL w1c_clear got %h want 0", readdata); else n_pass++;
    endtask

    task automatic test_overrun();
        in_port = 3'b010;
        repeat (4) cyc(3'd0, 1'b0, 32'h0);
        in_port = 3'b110;
        repeat (4) cyc(3'd0, 1'b0, 32'h0);
        in_port = 3'b010;
        repeat (4) cyc(3'd0, 1'b0, 32'h0);
        cyc(3'd7, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h4) $display("FAIL overrun_set got %h want 4", readdata); else n_pass++;
        cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h4) $display("FAIL overrun_capture got %h want 4", readdata); else n_pass++;
        n_chk++; if (irq !== 1'b0) $display("FAIL overrun_irq_masked got %b want 0", irq); else n_pass++;
        cyc(3'd7, 1'b1, 32'h4);
        cyc(3'd7, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h0) $display("FAIL overrun_w1c got %h want 0", readdata); else n_pass++;
        cyc(3'd3, 1'b1, 32'h7);
    endtask

    task automatic test_both_edges();
        logic [2:0]  ra [6];
        logic [31:0] re [6];
        ra = '{3'd3, 3'd4, 3'd7, 3'd6, 3'd2, 3'd5};
        re = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h7};
        in_port = 3'b111;
        repeat (5) cyc(3'd0, 1'b0, 32'h0);
        cyc(3'd4, 1'b1, 32'h1);
        cyc(3'd5, 1'b1, 32'h1);
        cyc(3'd3, 1'b1, 32'h7);
        cyc(3'd7, 1'b1, 32'h7);
        in_port = 3'b110;
        repeat (4) cyc(3'd0, 1'b0, 32'h0);
        cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h1) $display("FAIL both_fall got %h want 1", readdata); else n_pass++;
        cyc(3'd3, 1'b1, 32'h1);
        repeat (14) cyc(3'd3, 1'b0, 32'h0);
        in_port = 3'b111;
        repeat (4) cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h0) $display("FAIL both_cleared got %h want 0", readdata); else n_pass++;
        cyc(3'd3, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h1) $display("FAIL both_rise got %h want 1", readdata); else n_pass++;
        // reset in the middle of a long debounce
        cyc(3'd6, 1'b1, 32'd10);
        in_port = 3'b110;
        repeat (3) cyc(3'd0, 1'b0, 32'h0);
        reset_n = 1'b0;
        model_reset();
        #2;
        n_chk++; if (readdata !== 32'h0) $display("FAIL midreset_rd got %h want 0", readdata); else n_pass++;
        n_chk++; if (irq !== 1'b0) $display("FAIL midreset_irq got %b want 0", irq); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(3'd0, 1'b0, 32'h0);
        n_chk++; if (readdata !== 32'h0) $display("FAIL midreset_data got %h want 0", readdata); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            cyc(ra[i], 1'b0, 32'h0);
            n_chk++;
            if (readdata !== re[i]) $display("FAIL midreset_reg addr%0d got %h want %h", ra[i], readdata, re[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        hold_reset();
        in_port = 3'($urandom);
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) hold_reset();
            if ($urandom_range(0, 5) == 0) in_port = 3'($urandom);
            address    = 3'($urandom);
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(0, 5) != 0);
            writedata  = $urandom;
            if (address == 3'd6) writedata = 32'($urandom_range(0, 6));
            tick();
            n_chk++;
            if (readdata !== m_rd) $display("FAIL rand_readdata cyc%0d got %h want %h", n, readdata, m_rd);
            else n_pass++;
            n_chk++;
            if (irq !== m_irq) $display("FAIL rand_irq cyc%0d got %b want %b", n, irq, m_irq);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_chk  = 0;
        test_reset();
        test_fall_capture();
        test_debounce();
        test_w1c_race();
        test_overrun();
        test_both_edges();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
